// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the generalised traffic light controller.
//   phase_t     : 3-bit phase/state encoding (code 7 is unused and treated
//                 as illegal by the controller).
//   lamps_t     : one bit per lamp, NS group first, then EW group.
//   lamp_decode : Moore decode from phase code (and blink flop) to lamps.
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } phase_t;

  localparam int NUM_DIR = 2;  // index 0 = NS, index 1 = EW

  typedef struct packed {
    logic ns_green;
    logic ns_yellow;
    logic ns_red;
    logic ew_green;
    logic ew_yellow;
    logic ew_red;
  } lamps_t;

  // Anything that is not a recognised running phase (AR1, AR2 and the unused
  // code 7) decodes to all-red, so a corrupted state register is always safe.
  function automatic lamps_t lamp_decode(input logic [2:0] ph, input logic blink);
    lamps_t l;
    l = '0;
    case (ph)
      3'd0: begin l.ns_green  = 1'b1; l.ew_red = 1'b1; end
      3'd1: begin l.ns_yellow = 1'b1; l.ew_red = 1'b1; end
      3'd3: begin l.ew_green  = 1'b1; l.ns_red = 1'b1; end
      3'd4: begin l.ew_yellow = 1'b1; l.ns_red = 1'b1; end
      3'd6: begin l.ns_yellow = blink; l.ew_yellow = blink; end
      default: begin l.ns_red = 1'b1; l.ew_red = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_controller_gen_if.sv
// -----------------------------------------------------------------------------
// traffic_light_controller_gen_if
// Bundle of all controller I/O except clk/rst.
//   master : environment side (drives en, flash_mode, pedestrian requests).
//   slave  : controller side (drives lamps, walk lamps, phase, timer_cnt).
// -----------------------------------------------------------------------------
interface traffic_light_controller_gen_if #(
  parameter int WIDTH_TIMER = 8
);
  logic                   en;
  logic                   flash_mode;
  logic                   ped_req_ns;
  logic                   ped_req_ew;
  logic                   NS_green;
  logic                   NS_yellow;
  logic                   NS_red;
  logic                   EW_green;
  logic                   EW_yellow;
  logic                   EW_red;
  logic                   walk_ns;
  logic                   walk_ew;
  logic [2:0]             phase;
  logic [WIDTH_TIMER-1:0] timer_cnt;

  modport master (
    output en, flash_mode, ped_req_ns, ped_req_ew,
    input  NS_green, NS_yellow, NS_red, EW_green, EW_yellow, EW_red,
    input  walk_ns, walk_ew, phase, timer_cnt
  );

  modport slave (
    input  en, flash_mode, ped_req_ns, ped_req_ew,
    output NS_green, NS_yellow, NS_red, EW_green, EW_yellow, EW_red,
    output walk_ns, walk_ew, phase, timer_cnt
  );
endinterface

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter that times each controller phase.
//   clk, rst    : clock, synchronous active-high reset (loads RST_VAL)
//   load_i      : load load_val_i this cycle (has priority over counting)
//   load_val_i  : value to load (phase duration - 1)
//   en_i        : tick enable; counter decrements only when high
//   cnt_o       : remaining count
//   expire_o    : cnt_o == 0 while en_i is high (last enabled cycle of phase)
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             expire_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  // The owner reloads on every expiry, so the zero guard only matters if a
  // load is ever skipped; it keeps the counter parked rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign expire_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/traffic_light_controller_gen.sv
// -----------------------------------------------------------------------------
// traffic_light_controller_gen
// NS/EW intersection controller with integrated phase timer, all-red
// clearance, latched pedestrian requests, tick enable and night flash mode.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   tl  : slave side of traffic_light_controller_gen_if
//         in : en, flash_mode, ped_req_ns, ped_req_ew
//         out: NS_/EW_ green/yellow/red lamps, walk_ns, walk_ew,
//              phase (state code), timer_cnt (remaining count)
// All outputs come from registers; there is no input-to-output path.
// -----------------------------------------------------------------------------
module traffic_light_controller_gen
  import traffic_pkg::*;
#(
  parameter int WIDTH_TIMER = 8,
  parameter int GREEN_NS    = 10,
  parameter int GREEN_EW    = 10,
  parameter int YELLOW      = 3,
  parameter int ALL_RED     = 1,
  parameter int FLASH_HALF  = 4
) (
  input logic clk,
  input logic rst,
  traffic_light_controller_gen_if.slave tl
);

  // Every duration must fit the counter: 1 <= D <= 2^WIDTH_TIMER.
  localparam int     DURATIONS [5] = '{GREEN_NS, GREEN_EW, YELLOW, ALL_RED, FLASH_HALF};
  localparam longint MAX_DUR       = longint'(1) << WIDTH_TIMER;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dur_check
    if ((DURATIONS[gi] < 1) || (longint'(DURATIONS[gi]) > MAX_DUR)) begin : g_bad
      $error("traffic_light_controller_gen: duration index %0d out of range", gi);
    end
  end

  localparam logic [WIDTH_TIMER-1:0] LD_GNS = WIDTH_TIMER'(GREEN_NS - 1);
  localparam logic [WIDTH_TIMER-1:0] LD_GEW = WIDTH_TIMER'(GREEN_EW - 1);
  localparam logic [WIDTH_TIMER-1:0] LD_YEL = WIDTH_TIMER'(YELLOW - 1);
  localparam logic [WIDTH_TIMER-1:0] LD_AR  = WIDTH_TIMER'(ALL_RED - 1);
  localparam logic [WIDTH_TIMER-1:0] LD_FH  = WIDTH_TIMER'(FLASH_HALF - 1);

  phase_t                 state_q, state_d;
  logic                   blink_q, blink_d;
  logic [NUM_DIR-1:0]     pend_q, pend_d;
  logic [NUM_DIR-1:0]     walk_q, walk_d;
  logic [NUM_DIR-1:0]     ped_req;
  logic                   tmr_load;
  logic [WIDTH_TIMER-1:0] tmr_load_val;
  logic [WIDTH_TIMER-1:0] tmr_cnt;
  logic                   tmr_expire;
  lamps_t                 lamps;

  phase_timer #(
    .WIDTH   (WIDTH_TIMER),
    .RST_VAL (LD_GNS)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (tl.en),
    .cnt_o      (tmr_cnt),
    .expire_o   (tmr_expire)
  );

  // Next-state logic. Every phase change reloads the timer with the duration
  // of the phase being entered, so each phase lasts D enabled cycles.
  always_comb begin
    state_d      = state_q;
    blink_d      = blink_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      NS_G: if (tmr_expire) begin
        state_d = NS_Y; tmr_load = 1'b1; tmr_load_val = LD_YEL;
      end
      NS_Y: if (tmr_expire) begin
        state_d = AR1; tmr_load = 1'b1; tmr_load_val = LD_AR;
      end
      AR1: if (tmr_expire) begin
        tmr_load = 1'b1;
        if (tl.flash_mode) begin
          state_d = FLASH; tmr_load_val = LD_FH;
        end else begin
          state_d = EW_G;  tmr_load_val = LD_GEW;
        end
      end
      EW_G: if (tmr_expire) begin
        state_d = EW_Y; tmr_load = 1'b1; tmr_load_val = LD_YEL;
      end
      EW_Y: if (tmr_expire) begin
        state_d = AR2; tmr_load = 1'b1; tmr_load_val = LD_AR;
      end
      AR2: if (tmr_expire) begin
        tmr_load = 1'b1;
        if (tl.flash_mode) begin
          state_d = FLASH; tmr_load_val = LD_FH;
        end else begin
          state_d = NS_G;  tmr_load_val = LD_GNS;
        end
      end
      FLASH: if (tmr_expire) begin
        tmr_load = 1'b1;
        if (tl.flash_mode) begin
          blink_d      = ~blink_q;
          tmr_load_val = LD_FH;
        end else begin
          // Leave with the blink flop cleared so a later flash entry always
          // starts with the yellows dark for the first half-period.
          state_d      = AR2;
          blink_d      = 1'b0;
          tmr_load_val = LD_AR;
        end
      end
      default: begin
        // Unused code: recover through a clearance phase, ignoring en.
        state_d      = AR2;
        tmr_load     = 1'b1;
        tmr_load_val = LD_AR;
      end
    endcase
  end

  assign ped_req = {tl.ped_req_ew, tl.ped_req_ns};

  // Per-direction pedestrian latch and walk lamp. A request in the very
  // cycle of the transition into green is served immediately; a request
  // during green stays pending for the next green of that direction.
  for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_ped
    localparam phase_t GREEN_PH = (gi == 0) ? NS_G : EW_G;
    logic enter_green;
    logic leave_green;

    assign enter_green = (state_d == GREEN_PH) && (state_q != GREEN_PH);
    assign leave_green = (state_q == GREEN_PH) && (state_d != GREEN_PH);
    assign pend_d[gi]  = enter_green ? 1'b0 : (pend_q[gi] | ped_req[gi]);
    assign walk_d[gi]  = enter_green ? (pend_q[gi] | ped_req[gi]) :
                         leave_green ? 1'b0 : walk_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NS_G;
      blink_q <= 1'b0;
      pend_q  <= '0;
      walk_q  <= '0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
      walk_q  <= walk_d;
    end
  end

  assign lamps        = lamp_decode(state_q, blink_q);
  assign tl.NS_green  = lamps.ns_green;
  assign tl.NS_yellow = lamps.ns_yellow;
  assign tl.NS_red    = lamps.ns_red;
  assign tl.EW_green  = lamps.ew_green;
  assign tl.EW_yellow = lamps.ew_yellow;
  assign tl.EW_red    = lamps.ew_red;
  assign tl.walk_ns   = walk_q[0];
  assign tl.walk_ew   = walk_q[1];
  assign tl.phase     = state_q;
  assign tl.timer_cnt = tmr_cnt;

endmodule

// File: tb/tb_traffic_light_controller_gen.sv
module tb_traffic_light_controller_gen;
  import traffic_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  traffic_light_controller_gen_if #(.WIDTH_TIMER(W)) tl ();

  traffic_light_controller_gen #(
    .WIDTH_TIMER (W),
    .GREEN_NS    (4),
    .GREEN_EW    (3),
    .YELLOW      (2),
    .ALL_RED     (1),
    .FLASH_HALF  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tl  (tl)
  );

  always #5 clk = ~clk;

  // Expected lamps {NS_g,NS_y,NS_r,EW_g,EW_y,EW_r} for a phase code.
  function automatic logic [5:0] exp_lamps(input int ph, input logic blink);
    case (ph)
      0:       return 6'b100_001;
      1:       return 6'b010_001;
      3:       return 6'b001_100;
      4:       return 6'b001_010;
      6:       return blink ? 6'b010_010 : 6'b000_000;
      default: return 6'b001_001;
    endcase
  endfunction

  function automatic logic [5:0] got_lamps();
    return {tl.NS_green, tl.NS_yellow, tl.NS_red, tl.EW_green, tl.EW_yellow, tl.EW_red};
  endfunction

  // Leaves the bench at the negedge that starts cycle 0.
  task automatic do_reset(input logic en_v);
    @(negedge clk);
    rst = 1'b1;
    tl.en = en_v; tl.flash_mode = 1'b0; tl.ped_req_ns = 1'b0; tl.ped_req_ew = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    tl.flash_mode = 1'b1;
    for (int c = 0; c < 2; c++) begin
      $display("reset c=%0d phase=%0d tmr=%0d lamps=%b", c, tl.phase, tl.timer_cnt, got_lamps());
      n_cmp++; if (tl.phase !== 3'd0) begin n_bad++; $display("FAIL reset_phase c=%0d got=%0d exp=0", c, tl.phase); end
      n_cmp++; if (got_lamps() !== 6'b100_001) begin n_bad++; $display("FAIL reset_lamps c=%0d got=%b exp=100001", c, got_lamps()); end
      n_cmp++; if (tl.timer_cnt !== 8'd3) begin n_bad++; $display("FAIL reset_timer c=%0d got=%0d exp=3", c, tl.timer_cnt); end
      n_cmp++; if ({tl.walk_ns, tl.walk_ew} !== 2'b00) begin n_bad++; $display("FAIL reset_walk c=%0d got=%b exp=00", c, {tl.walk_ns, tl.walk_ew}); end
      @(negedge clk);  // en=0: nothing may move
    end
    tl.flash_mode = 1'b0;
  endtask

  task automatic test_free_run();
    int ph_tab [14] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
    int tm_tab [14] = '{3, 2, 1, 0, 1, 0, 0, 2, 1, 0, 1, 0, 0, 3};
    do_reset(1'b1);
    for (int c = 0; c < 14; c++) begin
      $display("free c=%0d phase=%0d tmr=%0d lamps=%b", c, tl.phase, tl.timer_cnt, got_lamps());
      n_cmp++; if (tl.phase !== 3'(ph_tab[c])) begin n_bad++; $display("FAIL free_phase c=%0d got=%0d exp=%0d", c, tl.phase, ph_tab[c]); end
      n_cmp++; if (tl.timer_cnt !== 8'(tm_tab[c])) begin n_bad++; $display("FAIL free_timer c=%0d got=%0d exp=%0d", c, tl.timer_cnt, tm_tab[c]); end
      n_cmp++; if (got_lamps() !== exp_lamps(ph_tab[c], 1'b0)) begin n_bad++; $display("FAIL free_lamps c=%0d got=%b exp=%b", c, got_lamps(), exp_lamps(ph_tab[c], 1'b0)); end
      n_cmp++; if ((tl.NS_green & tl.EW_green) !== 1'b0) begin n_bad++; $display("FAIL free_two_greens c=%0d got=1 exp=0", c); end
      @(negedge clk);
    end
  endtask

  task automatic test_enable_gating();
    int ep, et;
    do_reset(1'b0);
    for (int c = 0; c < 34; c++) begin
      if (c < 12)      begin ep = 0; et = 3 - c / 3; end
      else if (c < 18) begin ep = 1; et = 1 - (c - 12) / 3; end
      else if (c < 21) begin ep = 2; et = 0; end
      else if (c < 30) begin ep = 3; et = 2 - (c - 21) / 3; end
      else             begin ep = 4; et = 1 - (c - 30) / 3; end
      $display("gate c=%0d en=%0d phase=%0d tmr=%0d", c, (c % 3 == 2), tl.phase, tl.timer_cnt);
      n_cmp++; if (tl.phase !== 3'(ep)) begin n_bad++; $display("FAIL gate_phase c=%0d got=%0d exp=%0d", c, tl.phase, ep); end
      n_cmp++; if (tl.timer_cnt !== 8'(et)) begin n_bad++; $display("FAIL gate_timer c=%0d got=%0d exp=%0d", c, tl.timer_cnt, et); end
      tl.en = (c % 3 == 2);
      @(negedge clk);
    end
  endtask

  task automatic test_pedestrian();
    logic ew_exp, ns_exp;
    do_reset(1'b1);
    for (int c = 0; c < 23; c++) begin
      ew_exp = ((c >= 7) && (c <= 9)) || ((c >= 20) && (c <= 22));
      $display("ped_ew c=%0d phase=%0d walk_ns=%0d walk_ew=%0d", c, tl.phase, tl.walk_ns, tl.walk_ew);
      n_cmp++; if (tl.walk_ew !== ew_exp) begin n_bad++; $display("FAIL ped_walk_ew c=%0d got=%0d exp=%0d", c, tl.walk_ew, ew_exp); end
      n_cmp++; if (tl.walk_ns !== 1'b0) begin n_bad++; $display("FAIL ped_walk_ns_idle c=%0d got=%0d exp=0", c, tl.walk_ns); end
      tl.ped_req_ew = (c == 1) || (c == 8);
      @(negedge clk);
    end
    // NS request arriving in the very cycle before green is served at once.
    do_reset(1'b1);
    for (int c = 0; c < 18; c++) begin
      ns_exp = (c >= 13) && (c <= 16);
      $display("ped_ns c=%0d phase=%0d walk_ns=%0d walk_ew=%0d", c, tl.phase, tl.walk_ns, tl.walk_ew);
      n_cmp++; if (tl.walk_ns !== ns_exp) begin n_bad++; $display("FAIL ped_walk_ns c=%0d got=%0d exp=%0d", c, tl.walk_ns, ns_exp); end
      n_cmp++; if (tl.walk_ew !== 1'b0) begin n_bad++; $display("FAIL ped_walk_ew_idle c=%0d got=%0d exp=0", c, tl.walk_ew); end
      tl.ped_req_ns = (c == 12);
      @(negedge clk);
    end
    tl.ped_req_ns = 1'b0;
  endtask

  task automatic test_flash();
    int   ph_tab [17] = '{0, 0, 0, 0, 1, 1, 2, 6, 6, 6, 6, 5, 0, 0, 0, 0, 1};
    int   tm_tab [17] = '{3, 2, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 3, 2, 1, 0, 1};
    logic bl, wns;
    do_reset(1'b1);
    for (int c = 0; c < 17; c++) begin
      bl  = (c == 9) || (c == 10);
      wns = (c >= 12) && (c <= 15);
      $display("flash c=%0d phase=%0d tmr=%0d lamps=%b walk_ns=%0d", c, tl.phase, tl.timer_cnt, got_lamps(), tl.walk_ns);
      n_cmp++; if (tl.phase !== 3'(ph_tab[c])) begin n_bad++; $display("FAIL flash_phase c=%0d got=%0d exp=%0d", c, tl.phase, ph_tab[c]); end
      n_cmp++; if (tl.timer_cnt !== 8'(tm_tab[c])) begin n_bad++; $display("FAIL flash_timer c=%0d got=%0d exp=%0d", c, tl.timer_cnt, tm_tab[c]); end
      n_cmp++; if (got_lamps() !== exp_lamps(ph_tab[c], bl)) begin n_bad++; $display("FAIL flash_lamps c=%0d got=%b exp=%b", c, got_lamps(), exp_lamps(ph_tab[c], bl)); end
      n_cmp++; if (tl.walk_ns !== wns) begin n_bad++; $display("FAIL flash_walk_ns c=%0d got=%0d exp=%0d", c, tl.walk_ns, wns); end
      tl.flash_mode = (c >= 5) && (c < 9);
      tl.ped_req_ns = (c == 8);
      @(negedge clk);
    end
    tl.flash_mode = 1'b0;
    tl.ped_req_ns = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    for (int c = 0; c < 26; c++) begin
      $display("rstmid c=%0d phase=%0d tmr=%0d walk_ns=%0d", c, tl.phase, tl.timer_cnt, tl.walk_ns);
      if (c == 11) begin
        n_cmp++; if (tl.phase !== 3'd4) begin n_bad++; $display("FAIL rstmid_pre_phase got=%0d exp=4", tl.phase); end
      end
      if (c == 12) begin
        n_cmp++; if (tl.phase !== 3'd0) begin n_bad++; $display("FAIL rstmid_phase got=%0d exp=0", tl.phase); end
        n_cmp++; if (got_lamps() !== 6'b100_001) begin n_bad++; $display("FAIL rstmid_lamps got=%b exp=100001", got_lamps()); end
        n_cmp++; if (tl.timer_cnt !== 8'd3) begin n_bad++; $display("FAIL rstmid_timer got=%0d exp=3", tl.timer_cnt); end
        n_cmp++; if ({tl.walk_ns, tl.walk_ew} !== 2'b00) begin n_bad++; $display("FAIL rstmid_walk got=%b exp=00", {tl.walk_ns, tl.walk_ew}); end
      end
      if (c == 25) begin
        // The NS request latched before the reset must have been discarded.
        n_cmp++; if (tl.phase !== 3'd0) begin n_bad++; $display("FAIL rstmid_reentry_phase got=%0d exp=0", tl.phase); end
        n_cmp++; if (tl.walk_ns !== 1'b0) begin n_bad++; $display("FAIL rstmid_pend_cleared got=%0d exp=0", tl.walk_ns); end
      end
      rst = (c == 11);
      tl.ped_req_ns = (c == 3);
      @(negedge clk);
    end
    rst = 1'b0;
    tl.ped_req_ns = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset(1'b1);
    @(negedge clk);
    @(negedge clk);  // cycle 2, NS_G
    force dut.state_q = traffic_pkg::phase_t'(3'd7);
    #1;
    $display("illegal forced phase=%0d lamps=%b", tl.phase, got_lamps());
    n_cmp++; if (got_lamps() !== 6'b001_001) begin n_bad++; $display("FAIL illegal_lamps got=%b exp=001001", got_lamps()); end
    #1;
    release dut.state_q;
    @(negedge clk);
    $display("illegal next phase=%0d tmr=%0d lamps=%b", tl.phase, tl.timer_cnt, got_lamps());
    n_cmp++; if (tl.phase !== 3'd5) begin n_bad++; $display("FAIL illegal_to_ar2 got=%0d exp=5", tl.phase); end
    n_cmp++; if (tl.timer_cnt !== 8'd0) begin n_bad++; $display("FAIL illegal_ar2_timer got=%0d exp=0", tl.timer_cnt); end
    n_cmp++; if (got_lamps() !== 6'b001_001) begin n_bad++; $display("FAIL illegal_ar2_lamps got=%b exp=001001", got_lamps()); end
    @(negedge clk);
    $display("illegal after phase=%0d tmr=%0d", tl.phase, tl.timer_cnt);
    n_cmp++; if (tl.phase !== 3'd0) begin n_bad++; $display("FAIL illegal_to_nsg got=%0d exp=0", tl.phase); end
    n_cmp++; if (tl.timer_cnt !== 8'd3) begin n_bad++; $display("FAIL illegal_nsg_timer got=%0d exp=3", tl.timer_cnt); end
  endtask

  initial begin
    tl.en = 1'b0; tl.flash_mode = 1'b0; tl.ped_req_ns = 1'b0; tl.ped_req_ew = 1'b0;
    test_reset();
    test_free_run();
    test_enable_gating();
    test_pedestrian();
    test_flash();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/traffic_light_controller_gen.md
# traffic_light_controller_gen

Parametrised successor to the fixed 4-state NS/EW traffic light FSM. Integrates its own phase timer, so no external timer or load/done handshake is needed. Adds configurable per-phase durations, all-red clearance phases, latched pedestrian requests with walk outputs, a clock-enable tick input and a flashing-yellow night mode. It sits at the top of the intersection datapath and drives the lamp drivers directly.

## Interface
- WIDTH_TIMER, 8: phase counter width. Every duration must be ≥1 and ≤2^WIDTH_TIMER; violations are elaboration errors.
- GREEN_NS, 10: NS green duration, in enabled cycles.
- GREEN_EW, 10: EW green duration.
- YELLOW, 3: yellow duration, both directions.
- ALL_RED, 1: all-red clearance duration.
- FLASH_HALF, 4: half-period of the flash blink.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  tick enable; the timer and FSM advance only when it is high.
- flash_mode  in  1  level request for night flash mode.
- ped_req_ns, ped_req_ew  in  1 each  pedestrian request pulses, sampled every cycle.
- NS_green, NS_yellow, NS_red, EW_green, EW_yellow, EW_red  out  1 each  lamp outputs.
- walk_ns, walk_ew  out  1 each  walk lamps.
- phase  out  3  current state code.
- timer_cnt  out  WIDTH_TIMER  remaining count, for debug.

## Operation
- States and codes: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, FLASH=6.
- Sequence: NS_G→NS_Y→AR1→EW_G→EW_Y→AR2→NS_G.
- Timer:
  - On entry to a state, the counter loads duration−1.
  - It decrements when en=1.
  - The state ends on the cycle where counter==0 and en=1, so each state lasts exactly D enabled cycles.
- Flash entry: at the end of AR1 or AR2, if flash_mode=1, go to FLASH instead of the next green.
- Flash behaviour:
  - Counter loads FLASH_HALF−1.
  - At each expiry, blink toggles.
  - NS_yellow = EW_yellow = blink; every other lamp is 0.
- Flash exit: at a blink expiry with flash_mode=0, go to AR2 loaded with ALL_RED−1. AR2 then rechecks flash_mode as usual.
- Lamp decode is Moore, one-hot per direction:
  - NS_G: NS_green, EW_red.
  - NS_Y: NS_yellow, EW_red.
  - AR1/AR2: NS_red, EW_red.
  - EW_G: EW_green, NS_red.
  - EW_Y: EW_yellow, NS_red.
- Pedestrian requests:
  - ped_pend_x sets on ped_req_x=1.
  - On the transition into x-green, walk_x is set if ped_pend_x or ped_req_x is high in that cycle, and ped_pend_x is cleared.
  - walk_x clears on leaving x-green.
  - A request arriving during x-green re-latches and is served by the next x-green.
  - Requests are latched during FLASH and AR as well.
- en=0 freezes state, counter and blink. Pedestrian latching continues.
- Illegal state code (7): go to AR2, reload ALL_RED−1; lamps decode all-red that cycle.
- Simultaneous flash_mode change and expiry: the value sampled at the expiry edge decides.

## Timing
- Reset (rst high at an edge):
  - state NS_G, counter GREEN_NS−1, blink 0, pend and walk 0.
  - Outputs: NS_green=1, EW_red=1, all other lamps 0, phase=0, timer_cnt=GREEN_NS−1.
- Reset mid-phase or mid-flash aborts immediately to the reset state; no clearance is inserted.
- All state, counter, pend, walk and blink are registered. Lamps and phase are combinational from registers.
- Every output changes one cycle after the deciding edge. No input-to-output combinational path exists.
- With en held at 1, the full cycle period is GREEN_NS+GREEN_EW+2·YELLOW+2·ALL_RED clocks.

## Structure
- Package traffic_pkg:
  - phase encoding constants/typedef (3 bits).
  - lamp decode function.
- Sub-module phase_timer:
  - loadable WIDTH_TIMER down-counter.
  - Ports: load, load_val, en; outputs cnt, expire (cnt==0 & en).
- The top module holds the FSM, pedestrian latches, blink flop and lamp decode.

## Test plan
Bench parameters: GREEN_NS=4, GREEN_EW=3, YELLOW=2, ALL_RED=1, FLASH_HALF=2.
- Free run: reset, en=1, no requests → phase 0 for cycles 0–3, 1 for 4–5, 2 at 6, 3 for 7–9, 4 for 10–11, 5 at 12, 0 at 13. Lamps match the decode; never two greens at once.
- Enable gating: en=1 only every 3rd cycle → each phase lasts 3× its duration; timer_cnt holds while en=0.
- Pedestrian: ped_req_ew pulse at cycle 1 → walk_ew=1 for cycles 7–9 and 0 otherwise. A second pulse at cycle 8 → walk_ew=1 in the next EW_G (cycles 20–22), walk_ns stays 0.
- Flash entry/exit: flash_mode=1 from cycle 5 → FLASH entered at cycle 7; both yellows blink 0,0,1,1… with all reds 0. flash_mode=0 → AR2 for 1 cycle after the next blink expiry, then NS_G.
- Reset mid-EW_Y: rst at cycle 11 → next cycle phase=0, NS_green=1, timer_cnt=3, walk 0.
- Illegal state: force the state register to 7 → all lamps red, then phase=5 next cycle, then 0.
